// File: rtl/mips_pkg.sv
// Shared constants for the single-cycle MIPS datapath: widths, named
// register indices and ALU control encodings used by decode, ALU and benches.
package mips_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 2 ** ADDR_W;

   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
   localparam logic [ADDR_W-1:0] REG_AT   = 5'd1;
   localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;
   localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01
   } alu_ctl_e;

endpackage

// File: rtl/mips_reg_file.sv
// Architectural register file: two combinational read ports feeding the ALU,
// one synchronous write port for writeback, and a 2-bit carry/zero status
// register. Register 0 reads as zero regardless of writes or forwarding.
module mips_reg_file
   import mips_pkg::*;
#(
   parameter int DATA_W = mips_pkg::DATA_W,
   parameter int ADDR_W = mips_pkg::ADDR_W,
   parameter bit BYPASS = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              flag_we,
   input  logic              c_in,
   input  logic              z_in,
   output logic              c_q,
   output logic              z_q
);

   localparam int                N_ENT    = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_IDX = '0;

   logic [DATA_W-1:0] regs [N_ENT];
   logic              wr_live;

   // A write qualifies only when enabled and not aimed at the hardwired zero.
   assign wr_live = we && (wr_addr != ZERO_IDX);

   // Register array: async clear, every qualifying edge writes unconditionally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_ENT; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_live) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Read port 1: array read, optional same-cycle forward, zero index wins.
   always_comb begin
      rd1 = regs[rs_addr];
      if (BYPASS && wr_live && (wr_addr == rs_addr)) begin
         rd1 = wr_data;
      end
      if (rs_addr == ZERO_IDX) begin
         rd1 = '0;
      end
   end

   // Read port 2: same structure as port 1, indexed by rt_addr.
   always_comb begin
      rd2 = regs[rt_addr];
      if (BYPASS && wr_live && (wr_addr == rt_addr)) begin
         rd2 = wr_data;
      end
      if (rt_addr == ZERO_IDX) begin
         rd2 = '0;
      end
   end

   // Status flags: capture ALU carry/zero when enabled, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_q <= 1'b0;
         z_q <= 1'b0;
      end else if (flag_we) begin
         c_q <= c_in;
         z_q <= z_in;
      end
   end

   // An unknown write index with the enable up would corrupt an arbitrary entry.
   always_ff @(posedge clk) begin
      if (rst_n && we) begin
         assert (!$isunknown(wr_addr));
      end
   end

endmodule

// File: tb/tb_mips_reg_file.sv
// Directed bench for mips_reg_file. Two instances share stimulus: one with
// forwarding enabled and one without. Expectations are queued as stimulus is
// applied and drained against the DUT outputs once they have settled.
module tb_mips_reg_file;
   import mips_pkg::*;

   logic              clk;
   logic              rst_n;
   logic [ADDR_W-1:0] rs_addr, rt_addr, wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              we, flag_we, c_in, z_in;
   logic [DATA_W-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
   logic              c_b, z_b, c_n, z_n;

   int n_assert = 0;
   int n_fail   = 0;

   logic [DATA_W-1:0] model [32];

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } exp_t;
   exp_t sb [$];

   mips_reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) u_byp (
      .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rt_addr(rt_addr),
      .rd1(rd1_b), .rd2(rd2_b), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
      .flag_we(flag_we), .c_in(c_in), .z_in(z_in), .c_q(c_b), .z_q(z_b)
   );

   mips_reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) u_nob (
      .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rt_addr(rt_addr),
      .rd1(rd1_n), .rd2(rd2_n), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
      .flag_we(flag_we), .c_in(c_in), .z_in(z_in), .c_q(c_n), .z_q(z_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // sel: 0 rd1_b, 1 rd2_b, 2 rd1_n, 3 rd2_n, 4 c_b, 5 z_b, 6 c_n, 7 z_n
   function automatic logic [31:0] observe(int sel);
      case (sel)
         0: return rd1_b;
         1: return rd2_b;
         2: return rd1_n;
         3: return rd2_n;
         4: return {31'd0, c_b};
         5: return {31'd0, z_b};
         6: return {31'd0, c_n};
         default: return {31'd0, z_n};
      endcase
   endfunction

   task automatic push(string tag, int sel, logic [31:0] e);
      exp_t x;
      x.tag = tag;
      x.sel = sel;
      x.exp = e;
      sb.push_back(x);
   endtask

   task automatic push_reads(string tag, logic [31:0] e1, logic [31:0] e2);
      push({tag, "_rd1_byp"}, 0, e1);
      push({tag, "_rd2_byp"}, 1, e2);
      push({tag, "_rd1_nob"}, 2, e1);
      push({tag, "_rd2_nob"}, 3, e2);
   endtask

   task automatic push_flags(string tag, logic c, logic z);
      push({tag, "_c_byp"}, 4, {31'd0, c});
      push({tag, "_z_byp"}, 5, {31'd0, z});
      push({tag, "_c_nob"}, 6, {31'd0, c});
      push({tag, "_z_nob"}, 7, {31'd0, z});
   endtask

   task automatic drain();
      exp_t        e;
      logic [31:0] o;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = observe(e.sel);
         n_assert++;
         assert (o === e.exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", e.tag, o, e.exp);
         end
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      rs_addr = '0;
      rt_addr = '0;
      wr_addr = '0;
      wr_data = '0;
      we      = 1'b0;
      flag_we = 1'b0;
      c_in    = 1'b0;
      z_in    = 1'b0;
      for (int i = 0; i < 32; i++) model[i] = '0;

      // Power-on reset state
      repeat (2) @(posedge clk);
      #1;
      rs_addr = 5'd5;
      rt_addr = 5'd31;
      #1;
      push_reads("por", 32'h0, 32'h0);
      push_flags("por", 1'b0, 1'b0);
      drain();
      @(negedge clk);
      rst_n = 1'b1;

      // Fill every register with random data, set both flags
      for (int i = 1; i < 32; i++) begin
         @(negedge clk);
         we      = 1'b1;
         wr_addr = 5'(i);
         wr_data = $urandom;
         model[i] = wr_data;
         flag_we = (i == 1);
         c_in    = 1'b1;
         z_in    = 1'b1;
      end
      @(negedge clk);
      we      = 1'b0;
      flag_we = 1'b0;
      c_in    = 1'b0;
      z_in    = 1'b0;
      push_flags("flags_set", 1'b1, 1'b1);
      drain();
      for (int i = 0; i < 32; i++) begin
         rs_addr = 5'(i);
         rt_addr = 5'(31 - i);
         #1;
         push_reads("fill", model[i], model[31 - i]);
         drain();
      end

      // Reset clear while held low
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 32; i++) begin
         rs_addr = 5'(i);
         rt_addr = 5'(i ^ 5);
         #1;
         push_reads("rst_clear", 32'h0, 32'h0);
         drain();
      end
      push_flags("rst_clear", 1'b0, 1'b0);
      drain();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) model[i] = '0;

      // Write/read r5 on both ports
      @(negedge clk);
      we      = 1'b1;
      wr_addr = 5'd5;
      wr_data = 32'hDEADBEEF;
      rs_addr = 5'd1;
      rt_addr = 5'd2;
      @(posedge clk);
      #1;
      we      = 1'b0;
      wr_data = 32'h0;
      rs_addr = 5'd5;
      rt_addr = 5'd5;
      #1;
      push_reads("wr_r5", 32'hDEADBEEF, 32'hDEADBEEF);
      drain();

      // we=0 leaves r5 unchanged
      @(negedge clk);
      we      = 1'b0;
      wr_addr = 5'd5;
      wr_data = 32'h11111111;
      @(posedge clk);
      #1;
      push_reads("we0_hold", 32'hDEADBEEF, 32'hDEADBEEF);
      drain();

      // Register 0 ignores writes and forwarding
      @(negedge clk);
      we      = 1'b1;
      wr_addr = 5'd0;
      wr_data = 32'hFFFFFFFF;
      rs_addr = 5'd0;
      rt_addr = 5'd0;
      #1;
      push_reads("r0_pre", 32'h0, 32'h0);
      drain();
      @(posedge clk);
      #1;
      push_reads("r0_post", 32'h0, 32'h0);
      drain();

      // Forwarding: r7 written while both ports read it
      @(negedge clk);
      we      = 1'b1;
      wr_addr = 5'd7;
      wr_data = 32'h12345678;
      rs_addr = 5'd7;
      rt_addr = 5'd7;
      #1;
      push("byp_pre_rd1_byp", 0, 32'h12345678);
      push("byp_pre_rd2_byp", 1, 32'h12345678);
      push("byp_pre_rd1_nob", 2, 32'h0);
      push("byp_pre_rd2_nob", 3, 32'h0);
      drain();
      @(posedge clk);
      #1;
      we = 1'b0;
      #1;
      push_reads("byp_post", 32'h12345678, 32'h12345678);
      drain();

      // Forward on rt only while rs reads a stored entry; boundary index 31
      @(negedge clk);
      we      = 1'b1;
      wr_addr = 5'd31;
      wr_data = 32'hCAFEF00D;
      rs_addr = 5'd5;
      rt_addr = 5'd31;
      #1;
      push("byp31_rd1_byp", 0, 32'hDEADBEEF);
      push("byp31_rd2_byp", 1, 32'hCAFEF00D);
      push("byp31_rd1_nob", 2, 32'hDEADBEEF);
      push("byp31_rd2_nob", 3, 32'h0);
      drain();
      @(posedge clk);
      #1;
      we = 1'b0;
      #1;
      push_reads("r31_post", 32'hDEADBEEF, 32'hCAFEF00D);
      drain();

      // Reset falls 1 ns before a write edge: write is lost
      @(negedge clk);
      we      = 1'b1;
      wr_addr = 5'd9;
      wr_data = 32'hA5A5A5A5;
      #4;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      we      = 1'b0;
      rst_n   = 1'b1;
      rs_addr = 5'd9;
      rt_addr = 5'd5;
      #1;
      push_reads("rst_collide", 32'h0, 32'h0);
      drain();

      // Flag capture then hold
      @(negedge clk);
      flag_we = 1'b1;
      c_in    = 1'b1;
      z_in    = 1'b0;
      @(posedge clk);
      #1;
      push_flags("flag_cap", 1'b1, 1'b0);
      drain();
      @(negedge clk);
      flag_we = 1'b0;
      c_in    = 1'b0;
      z_in    = 1'b1;
      @(posedge clk);
      #1;
      push_flags("flag_hold", 1'b1, 1'b0);
      drain();

      // Flags and register write on the same edge
      @(negedge clk);
      flag_we = 1'b1;
      c_in    = 1'b0;
      z_in    = 1'b1;
      we      = 1'b1;
      wr_addr = 5'd29;
      wr_data = 32'h0BADC0DE;
      @(posedge clk);
      #1;
      flag_we = 1'b0;
      we      = 1'b0;
      rs_addr = 5'd29;
      rt_addr = 5'd9;
      #1;
      push_flags("flag_both", 1'b0, 1'b1);
      push_reads("wr_both", 32'h0BADC0DE, 32'h0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mips_reg_file.md
Name: mips_reg_file

Overview:
- Architectural register file for the single-cycle MIPS datapath.
- Sits directly upstream of the ALU: two combinational read ports supply operands A and B.
- One synchronous write port takes the writeback result (ALU_out or load data).
- Also holds a 2-bit status register that captures the ALU carry and zero flags for later inspection and branch logic.

Parameters:
- DATA_W, 32, register and port data width
- ADDR_W, 5, register index width; NUM_REGS = 2**ADDR_W
- BYPASS, 1, 1 = same-cycle write-to-read forwarding; 0 = read returns the pre-edge value

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- rs_addr  in  ADDR_W  read port 1 index (instr[25:21])
- rt_addr  in  ADDR_W  read port 2 index (instr[20:16])
- rd1  out  DATA_W  read port 1 data, feeds ALU A
- rd2  out  DATA_W  read port 2 data, feeds ALU B / store data
- we  in  1  register write enable
- wr_addr  in  ADDR_W  write index (rd or rt, selected upstream)
- wr_data  in  DATA_W  write data
- flag_we  in  1  status capture enable
- c_in  in  1  ALU carry flag
- z_in  in  1  ALU zero flag
- c_q  out  1  registered carry flag
- z_q  out  1  registered zero flag

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset: rst_n low immediately clears all NUM_REGS entries, c_q and z_q to 0.
  - rd1 and rd2 therefore read 0 while reset is held.
  - Release is synchronised upstream; the block adds no reset synchroniser.
- Write: on a rising clk with rst_n high, we=1 and wr_addr!=0, entry[wr_addr] <= wr_data.
  - Write latency is 1 edge.
  - we=0 leaves all entries unchanged.
- Register 0: hardwired to 0.
  - Writes with wr_addr=0 are dropped.
  - rs_addr=0 or rt_addr=0 always reads 0, including under bypass.
- Read: purely combinational from the address inputs, zero cycles of latency.
  - rd1 = entry[rs_addr]; rd2 = entry[rt_addr].
  - Both ports may address the same entry at once.
- Bypass (BYPASS=1):
  - If we=1, wr_addr!=0 and wr_addr==rs_addr, rd1 = wr_data in the same cycle. Same rule for rt_addr and rd2.
  - Both ports may be forwarded together.
- Bypass off (BYPASS=0): a read of the entry being written returns the old value until the edge, then the new one.
- Flags: on a rising clk with flag_we=1, c_q <= c_in and z_q <= z_in.
  - Otherwise the flags hold.
  - Flag capture is independent of we; both may occur on the same edge.
- Simultaneous reset and write edge: reset wins; the write is lost and the entry stays 0.
- Reset asserted mid-program: all contents are lost. No partial state survives.
- No state machine. All sequential state is the NUM_REGS x DATA_W array plus 2 flag flops.
  - A write-only-if-changed optimisation is forbidden: every qualifying edge writes.
- Inputs are assumed X-free after reset release. An X on wr_addr with we=1 is a bench error and is flagged by assertion.

Decomposition:
- Shared package mips_pkg:
  - DATA_W and ADDR_W constants.
  - REG_ZERO=0, REG_AT=1, REG_SP=29, REG_RA=31.
  - The ALU_ctl encodings ADD=2'b00 and SUB=2'b01, so decode, ALU and benches agree.
- No sub-module. The bypass mux is one conditional per port and the flag register is two flops, both inline.

Test Plan:
- Reset clear: hold rst_n=0 after random writes -> rd1=rd2=0 for all 32 addresses; c_q=z_q=0.
- Write/read: we=1, wr_addr=5, wr_data=32'hDEADBEEF, one edge; rs_addr=5 -> rd1=32'hDEADBEEF. rt_addr=5 at the same time -> rd2 equal.
- Register 0: we=1, wr_addr=0, wr_data=32'hFFFFFFFF -> rd1 with rs_addr=0 is 0, both before and after the edge.
- Bypass: BYPASS=1, we=1, wr_addr=rs_addr=7, wr_data=32'h12345678 -> rd1=32'h12345678 before the edge. BYPASS=0 -> rd1 holds its old value 32'h0 until the edge.
- Async reset collision: write 32'hA5A5A5A5 to r9 while rst_n falls 1 ns before the edge -> r9 reads 0 after reset release.
- Flags: flag_we=1, c_in=1, z_in=0, one edge -> c_q=1, z_q=0. Then flag_we=0 with c_in=0, z_in=1 -> c_q=1, z_q=0 held.
